// File: rtl/sipo_rx_if.sv
// Parallel-side and serial-side signal bundle for sipo_rx.
// The master modport drives the link, and the slave modport is the receiver.
interface sipo_rx_if #(
    parameter int WIDTH = 4
);
    logic             Start;
    logic             Dir;
    logic             Ser_In;
    logic             Ser_Valid;
    logic             Data_Ack;
    logic [WIDTH-1:0] Data_Out;
    logic             Data_Valid;
    logic             Busy;
    logic             Overrun;
    logic             Parity_Err;

    modport master (
        output Start, Dir, Ser_In, Ser_Valid, Data_Ack,
        input  Data_Out, Data_Valid, Busy, Overrun, Parity_Err
    );

    modport slave (
        input  Start, Dir, Ser_In, Ser_Valid, Data_Ack,
        output Data_Out, Data_Valid, Busy, Overrun, Parity_Err
    );
endinterface

// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver with a valid/ack parallel handshake and a sticky overrun flag.
// Define PARITY_CHK_EN to append an even-parity bit to each frame and report it on Parity_Err.
module sipo_rx #(
    parameter int WIDTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    sipo_rx_if.slave bus
);

`ifdef PARITY_CHK_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME - 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid;
    logic             r_overrun;
    logic             r_parity_err;

    logic             w_take;
    logic             w_last;
    logic             w_load;
    logic             w_shift_en;
    logic [WIDTH-1:0] w_sr_shift;
    logic [WIDTH-1:0] w_word;
    logic             w_parity_err;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: if (bus.Start) w_next_state = RECV;
            RECV: begin
                w_take = bus.Ser_Valid;
                w_last = bus.Ser_Valid && (r_cnt == LAST_IDX);
                if (w_last) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_sr_shift = r_dir ? {r_sr[WIDTH-2:0], bus.Ser_In}
                              : {bus.Ser_In, r_sr[WIDTH-1:1]};

`ifdef PARITY_CHK_EN
    // The trailing parity bit is checked against the assembled data, never shifted in.
    assign w_shift_en   = w_take && !w_last;
    assign w_word       = r_sr;
    assign w_parity_err = (^r_sr) ^ bus.Ser_In;
`else
    assign w_shift_en   = w_take;
    assign w_word       = w_sr_shift;
    assign w_parity_err = 1'b0;
`endif

    // A completed word is accepted when the slot is free or being freed on this same edge.
    assign w_load = w_last && (!r_data_valid || bus.Data_Ack);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_dir        <= 1'b0;
            r_sr         <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (r_state == IDLE && bus.Start) begin
                r_dir <= bus.Dir;
                r_cnt <= '0;
                r_sr  <= '0;
            end else if (w_take) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_shift_en) r_sr <= w_sr_shift;
            end

            if (w_load) begin
                r_data_out   <= w_word;
                r_data_valid <= 1'b1;
                r_parity_err <= w_parity_err;
            end else if (bus.Data_Ack) begin
                r_data_valid <= 1'b0;
                r_parity_err <= 1'b0;
            end

            if (w_last && r_data_valid && !bus.Data_Ack) r_overrun <= 1'b1;
        end
    end

    assign bus.Data_Out   = r_data_out;
    assign bus.Data_Valid = r_data_valid;
    assign bus.Busy       = (r_state == RECV);
    assign bus.Overrun    = r_overrun;
`ifdef PARITY_CHK_EN
    assign bus.Parity_Err = r_parity_err;
`else
    assign bus.Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx: directed scenarios plus randomized frames
// checked against a frame-level model of the receive and handshake rules.
module tb_sipo_rx;

    localparam int W = 4;
`ifdef PARITY_CHK_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = W + PAR;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sipo_rx_if #(.WIDTH(W)) bus ();

    sipo_rx #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected state of the parallel side.
    logic [W-1:0] exp_data;
    logic         exp_valid;
    logic         exp_overrun;
    logic         exp_perr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data"},    32'(bus.Data_Out),   32'(exp_data));
        check({tag, ".valid"},   32'(bus.Data_Valid), 32'(exp_valid));
        check({tag, ".overrun"}, 32'(bus.Overrun),    32'(exp_overrun));
        check({tag, ".perr"},    32'(bus.Parity_Err), 32'(exp_perr));
    endtask

    task automatic model_reset();
        exp_data    = '0;
        exp_valid   = 1'b0;
        exp_overrun = 1'b0;
        exp_perr    = 1'b0;
    endtask

    task automatic model_ack();
        exp_valid = 1'b0;
        exp_perr  = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.Start     = 1'b0;
        bus.Dir       = 1'b0;
        bus.Ser_In    = 1'b0;
        bus.Ser_Valid = 1'b0;
        bus.Data_Ack  = 1'b0;
    endtask

    task automatic do_ack(input string tag);
        bus.Data_Ack = 1'b1;
        tick();
        bus.Data_Ack = 1'b0;
        model_ack();
        check_outputs(tag);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // Sends one frame: Start cycle, then the bits with `gap` stall cycles before each.
    // With noisy=1, Start and Data_Ack toggle randomly in non-final cycles.
    task automatic send_frame(input string tag, input logic [W-1:0] word, input logic dir,
                              input int gap, input logic ack_last, input logic par_bit,
                              input logic noisy);
        logic [W-1:0] w;
        logic         b;
        logic         a;
        w = word;
        bus.Start     = 1'b1;
        bus.Dir       = dir;
        bus.Ser_Valid = noisy ? 1'($urandom) : 1'b0;
        bus.Ser_In    = 1'($urandom);
        bus.Data_Ack  = 1'b0;
        tick();
        bus.Start = 1'b0;
        check({tag, ".busy_start"}, 32'(bus.Busy), 32'd1);
        for (int i = 0; i < FRAME; i++) begin
            if (i < W) b = dir ? w[W-1-i] : w[i];
            else       b = par_bit;
            for (int g = 0; g < gap; g++) begin
                a = noisy ? 1'($urandom_range(0, 3) == 0) : 1'b0;
                bus.Ser_Valid = 1'b0;
                bus.Ser_In    = 1'($urandom);
                bus.Start     = noisy ? 1'($urandom) : 1'b0;
                bus.Data_Ack  = a;
                tick();
                if (a) model_ack();
                check({tag, ".stall_valid"}, 32'(bus.Data_Valid), 32'(exp_valid));
                check({tag, ".stall_busy"},  32'(bus.Busy),       32'd1);
            end
            bus.Ser_Valid = 1'b1;
            bus.Ser_In    = b;
            bus.Start     = noisy ? 1'($urandom) : 1'b0;
            if (i == FRAME - 1) a = ack_last;
            else                a = noisy ? 1'($urandom_range(0, 3) == 0) : 1'b0;
            bus.Data_Ack = a;
            tick();
            if (i == FRAME - 1) begin
                if (exp_valid && !a) begin
                    exp_overrun = 1'b1;
                end else begin
                    exp_data  = word;
                    exp_valid = 1'b1;
                    exp_perr  = (PAR == 1) ? ((^word) ^ par_bit) : 1'b0;
                end
            end else if (a) begin
                model_ack();
            end
        end
        idle_inputs();
        check({tag, ".busy_done"}, 32'(bus.Busy), 32'd0);
        check_outputs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        model_reset();
        apply_reset();
        check({"reset", ".busy"}, 32'(bus.Busy), 32'd0);
        check_outputs("reset");

        // LSB-first capture 1,1,0,1 -> 4'hB
        send_frame("lsb", 4'hB, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        do_ack("lsb_ack");

        // MSB-first capture with a one-cycle stall before each bit
        send_frame("msb", 4'hB, 1'b1, 1, 1'b0, 1'b1, 1'b0);
        do_ack("msb_ack");

        // Overrun: 4'h3 left pending, 4'hC is dropped
        send_frame("ovr_a", 4'h3, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        send_frame("ovr_b", 4'hC, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        check("ovr_data_kept", 32'(bus.Data_Out), 32'h3);
        do_ack("ovr_ack");
        check("ovr_sticky", 32'(bus.Overrun), 32'd1);

        // Ack coinciding with completion replaces the pending word without overrun
        apply_reset();
        send_frame("sim_a", 4'hA, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        send_frame("sim_b", 4'h5, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        check("sim_data", 32'(bus.Data_Out), 32'h5);
        check("sim_ovr",  32'(bus.Overrun),  32'd0);

        // Asynchronous reset after two bits of a frame, with a word still pending
        bus.Start = 1'b1;
        bus.Dir   = 1'b0;
        tick();
        bus.Start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.Ser_Valid = 1'b1;
            bus.Ser_In    = 1'b1;
            tick();
        end
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst_busy", 32'(bus.Busy), 32'd0);
        check_outputs("arst");
        tick();
        rst = 1'b0;
        tick();
        send_frame("post_rst", 4'h6, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        do_ack("post_rst_ack");

        // Parity: correct bit for 4'hB is 1
        send_frame("par_ok", 4'hB, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        do_ack("par_ok_ack");
        send_frame("par_bad", 4'hB, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        do_ack("par_bad_ack");

        // Randomized frames, with back-to-back starts when no ack/idle is inserted
        for (int n = 0; n < 60; n++) begin
            send_frame("rnd", W'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                       1'($urandom), 1'($urandom), 1'b1);
            if ($urandom_range(0, 2) == 0) do_ack("rnd_ack");
            if ($urandom_range(0, 3) == 0) begin
                bus.Data_Ack = 1'b0;
                tick();
                check_outputs("rnd_idle");
            end
            if (n == 30) apply_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
- Serial-to-parallel receiver: the receive end of the serial shift link.
- Captures a WIDTH-bit word from a serial bit stream. The stream is taken from a shift register's LSB_out (right shift, LSB first) or MSB_out (left shift, MSB first).
- Presents the captured word on a registered parallel output with a valid/acknowledge handshake.
- Sits between a serial shifter and parallel consumer logic.

Parameters:
- WIDTH, 4, word length in bits (>= 2).

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- Start  input  1  begin a frame; sampled only in IDLE.
- Dir  input  1  bit order, latched at Start: 0 = LSB first, 1 = MSB first.
- Ser_In  input  1  serial data bit.
- Ser_Valid  input  1  Ser_In is valid this cycle; sampled only in RECV.
- Data_Ack  input  1  consumer accepts Data_Out.
- Data_Out  output  WIDTH  received word (registered).
- Data_Valid  output  1  Data_Out holds an unacknowledged word.
- Busy  output  1  high while in RECV.
- Overrun  output  1  sticky: a word completed while the previous word was unacknowledged.
- Parity_Err  output  1  parity result for the word on Data_Out (see Optional Feature).

Behaviour:
- Reset (async, any state, including mid-frame):
  - state = IDLE; bit counter = 0; shift reg = 0.
  - Data_Out = 0, Data_Valid = 0, Busy = 0, Overrun = 0, Parity_Err = 0.
  - Any partial frame is discarded.
- FSM, two states:
  - IDLE:
    - Start = 1 -> RECV at next edge; Dir latched; counter cleared.
    - Ser_Valid in the Start cycle is ignored.
  - RECV:
    - Each edge with Ser_Valid = 1 samples one bit and increments the counter.
    - Ser_Valid = 0 stalls; there is no timeout.
    - Start is ignored in RECV.
    - On the edge sampling the last frame bit: -> IDLE.
- Assembly:
  - Dir = 0: sr <= {Ser_In, sr[WIDTH-1:1]}, so the first bit ends in bit 0.
  - Dir = 1: sr <= {sr[WIDTH-2:0], Ser_In}, so the first bit ends in bit WIDTH-1.
- Completion:
  - On the final-bit edge, the fully assembled word, including the final bit, is the completed word.
  - If it is loaded (see Handshake), Data_Out and Data_Valid = 1 are visible the cycle after the final bit is presented.
  - Latency from final-bit presentation to Data_Valid = 1 edge.
- Handshake:
  - Data_Valid stays high until an edge with Data_Ack = 1, then clears.
  - Data_Ack with Data_Valid = 0 has no effect.
  - Completion and Data_Ack on the same edge: Data_Out loads the new word, Data_Valid stays 1, no overrun.
  - Completion with Data_Valid = 1 and Data_Ack = 0:
    - Data_Out keeps the old word.
    - The new word is dropped.
    - Overrun <= 1, sticky until rst.
- Back-to-back frames:
  - Start may be asserted the cycle after completion (IDLE).
  - Minimum frame period is WIDTH + 1 cycles.
- Busy = (state == RECV).

Optional Feature:
- Macro PARITY_CHK_EN.
- Defined:
  - Frame is WIDTH + 1 bits; the final bit is an even-parity bit over the WIDTH data bits.
  - The parity bit is not shifted into sr.
  - On completion, Parity_Err <= (^data) ^ parity_bit, loaded together with Data_Out under the same load/drop rules.
  - Parity_Err clears together with Data_Valid on acknowledge.
- Undefined:
  - Frame is WIDTH bits.
  - Parity_Err is a constant 0.
  - No parity logic is present.

Test Plan:
- LSB-first capture: WIDTH = 4, Start with Dir = 0, then bits 1,1,0,1 on consecutive Ser_Valid cycles -> Data_Out = 4'hB, Data_Valid = 1 the cycle after the 4th bit, Busy low.
- MSB-first capture with stalls: Dir = 1, bits 1,0,1,1 with one Ser_Valid = 0 gap between each bit -> Data_Out = 4'hB. Data_Valid stays 0 until the 4th bit.
- Handshake and overrun:
  - Receive 4'h3 without acknowledging, then receive 4'hC -> Data_Out = 4'h3, Overrun = 1.
  - Data_Ack -> Data_Valid = 0; Overrun remains 1.
- Simultaneous acknowledge and completion: Data_Ack on the final-bit edge of word 4'h5 while 4'hA is pending -> Data_Out = 4'h5, Data_Valid = 1, Overrun = 0.
- Reset mid-frame: rst asserted asynchronously after 2 bits -> all outputs 0 immediately. A new full frame 4'h6 then captures correctly with no residue.
- Parity (PARITY_CHK_EN defined):
  - Data 4'hB with parity bit 1 -> Parity_Err = 0.
  - Data 4'hB with parity bit 0 -> Parity_Err = 1.
  - Without the macro, the 4-bit frame 4'hB -> Parity_Err = 0.
